// File: rtl/mul_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mul_acc_pkg
// Brief    : Shared FSM state type and width-generic extension / add helpers
//            for the multiplier product accumulator.
// Revision : 1.0 - initial release
// ============================================================================
package mul_acc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Helpers operate on a fixed wide container so any acc_w up to this width works.
    localparam int C_MAX_W = 128;

    function automatic logic [C_MAX_W-1:0] extend_to_max(
        input logic [C_MAX_W-1:0] value,
        input int                 src_w,
        input logic               is_signed
    );
        logic [C_MAX_W-1:0] mask;
        logic [C_MAX_W-1:0] shifted;
        mask          = (C_MAX_W'(1) << src_w) - C_MAX_W'(1);
        shifted       = value >> (src_w - 1);
        extend_to_max = value & mask;
        if (is_signed && shifted[0]) begin
            extend_to_max = extend_to_max | ~mask;
        end
    endfunction

    // Returns {result, overflow}; a w-bit signed add done in the wide container
    // overflows exactly when the wide result no longer fits back into w bits.
    function automatic logic [C_MAX_W:0] acc_add(
        input logic [C_MAX_W-1:0] a,
        input logic [C_MAX_W-1:0] b,
        input int                 w,
        input logic               sat_en
    );
        logic [C_MAX_W-1:0] full;
        logic [C_MAX_W-1:0] limit;
        logic               ovf;
        full  = extend_to_max(a, w, 1'b1) + extend_to_max(b, w, 1'b1);
        ovf   = (extend_to_max(full, w, 1'b1) != full);
        limit = (C_MAX_W'(1) << (w - 1)) - C_MAX_W'(1);
        if (ovf && sat_en) begin
            full = full[C_MAX_W-1] ? ~limit : limit;
        end
        acc_add = {full, ovf};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_acc_extend.sv
`default_nettype none
// ============================================================================
// Module   : mul_acc_extend
// Brief    : Sign- or zero-extends a 2*n-bit product to the accumulator width.
// Revision : 1.0 - initial release
// ============================================================================
module mul_acc_extend
    import mul_acc_pkg::*;
#(
    parameter int n     = 8,
    parameter int acc_w = 2*n+8
) (
    input  logic [2*n-1:0]   prod,
    input  logic             prod_signed,
    output logic [acc_w-1:0] prod_ext
);

    assign prod_ext = acc_w'(extend_to_max(C_MAX_W'(prod), 2*n, prod_signed));

endmodule
`default_nettype wire

// File: rtl/mul_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : mul_product_accumulator
// Brief    : Accumulates framed 2*n-bit products into one signed sum per frame,
//            delivered over a valid/ready handshake. Define MUL_ACC_SAT_EN to
//            clamp on overflow instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module mul_product_accumulator
    import mul_acc_pkg::*;
#(
    parameter int n     = 8,
    parameter int acc_w = 2*n+8,
    parameter int cnt_w = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             prod_valid,
    output logic             prod_ready,
    input  logic [2*n-1:0]   prod,
    input  logic             prod_signed,
    input  logic             prod_last,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic [acc_w-1:0] sum,
    output logic [cnt_w-1:0] sum_count,
    output logic             sum_ovf
);

`ifdef MUL_ACC_SAT_EN
    localparam logic c_sat_en = 1'b1;
`else
    localparam logic c_sat_en = 1'b0;
`endif

    state_t           r_state;
    state_t           w_state_next;
    logic [acc_w-1:0] r_acc;
    logic [acc_w-1:0] w_prod_ext;
    logic [acc_w-1:0] w_acc_base;
    logic [acc_w-1:0] w_acc_next;
    logic             w_add_ovf;
    logic [cnt_w-1:0] r_count;
    logic [cnt_w-1:0] w_count_next;
    logic             r_ovf;
    logic             w_accept;
    logic [acc_w-1:0] r_sum;
    logic [cnt_w-1:0] r_sum_count;
    logic             r_sum_ovf;

    mul_acc_extend #(
        .n     (n),
        .acc_w (acc_w)
    ) u_extend (
        .prod        (prod),
        .prod_signed (prod_signed),
        .prod_ext    (w_prod_ext)
    );

    assign prod_ready = (r_state != HOLD);
    assign sum_valid  = (r_state == HOLD);
    assign sum        = r_sum;
    assign sum_count  = r_sum_count;
    assign sum_ovf    = r_sum_ovf;

    assign w_accept     = prod_valid && prod_ready;
    assign w_acc_base   = (r_state == IDLE) ? '0 : r_acc;
    assign {w_acc_next, w_add_ovf} =
        (acc_w+1)'(acc_add(C_MAX_W'(w_acc_base), C_MAX_W'(w_prod_ext), acc_w, c_sat_en));
    assign w_count_next = (r_count == {cnt_w{1'b1}}) ? r_count : r_count + cnt_w'(1);

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE, ACC: begin
                if (w_accept) begin
                    w_state_next = prod_last ? HOLD : ACC;
                end
            end
            HOLD: begin
                if (sum_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_sum       <= '0;
            r_sum_count <= '0;
            r_sum_ovf   <= 1'b0;
        end else if (w_accept) begin
            if (prod_last) begin
                r_sum       <= w_acc_next;
                r_sum_count <= w_count_next;
                r_sum_ovf   <= r_ovf | w_add_ovf;
                r_acc       <= '0;
                r_count     <= '0;
                r_ovf       <= 1'b0;
            end else begin
                r_acc       <= w_acc_next;
                r_count     <= w_count_next;
                r_ovf       <= r_ovf | w_add_ovf;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_product_accumulator
// Brief    : Scoreboard bench for mul_product_accumulator (n=8 and n=4 builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_product_accumulator;

    typedef struct {
        logic [23:0] sum;
        logic [7:0]  cnt;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        prod_valid;
    logic        prod_ready;
    logic [15:0] prod;
    logic        prod_signed;
    logic        prod_last;
    logic        sum_valid;
    logic        sum_ready;
    logic [23:0] sum;
    logic [7:0]  sum_count;
    logic        sum_ovf;

    logic        p4_valid;
    logic        p4_ready;
    logic [7:0]  p4_prod;
    logic        p4_signed;
    logic        p4_last;
    logic        s4_valid;
    logic [7:0]  s4_sum;
    logic [7:0]  s4_count;
    logic        s4_ovf;

    int          vectors;
    int          miscompares;
    exp_t        sb[$];
    longint      m_acc;
    int          m_cnt;
    logic        m_ovf;

    mul_product_accumulator #(.n(8), .acc_w(24), .cnt_w(8)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .prod_valid  (prod_valid),
        .prod_ready  (prod_ready),
        .prod        (prod),
        .prod_signed (prod_signed),
        .prod_last   (prod_last),
        .sum_valid   (sum_valid),
        .sum_ready   (sum_ready),
        .sum         (sum),
        .sum_count   (sum_count),
        .sum_ovf     (sum_ovf)
    );

    mul_product_accumulator #(.n(4), .acc_w(8), .cnt_w(8)) u_dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .prod_valid  (p4_valid),
        .prod_ready  (p4_ready),
        .prod        (p4_prod),
        .prod_signed (p4_signed),
        .prod_last   (p4_last),
        .sum_valid   (s4_valid),
        .sum_ready   (1'b1),
        .sum         (s4_sum),
        .sum_count   (s4_count),
        .sum_ovf     (s4_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_clear();
        m_acc = 0;
        m_cnt = 0;
        m_ovf = 1'b0;
    endtask

    // Reference: 24-bit signed accumulate with wrap or clamp.
    task automatic model_add(input logic [15:0] p, input logic s, input logic last);
        longint v;
        longint t;
        exp_t   e;
        v = s ? longint'($signed(p)) : longint'({48'd0, p});
        t = m_acc + v;
        if (t > 64'sd8388607 || t < -64'sd8388608) begin
            m_ovf = 1'b1;
`ifdef MUL_ACC_SAT_EN
            t = (t > 0) ? 64'sd8388607 : -64'sd8388608;
`else
            t = ((t + 64'sd8388608) & 64'sd16777215) - 64'sd8388608;
`endif
        end
        m_acc = t;
        if (m_cnt < 255) m_cnt++;
        if (last) begin
            e.sum = 24'(m_acc);
            e.cnt = 8'(m_cnt);
            e.ovf = m_ovf;
            sb.push_back(e);
            model_clear();
        end
    endtask

    task automatic send_beat(input logic [15:0] p, input logic s, input logic last);
        int waited;
        waited      = 0;
        prod        = p;
        prod_signed = s;
        prod_last   = last;
        prod_valid  = 1'b1;
        while (prod_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (prod_ready !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: prod_ready=%b required 1", prod_ready);
            prod_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_add(p, s, last);
        @(negedge clk);
        prod_valid = 1'b0;
        prod_last  = 1'b0;
    endtask

    task automatic get_sum(input int hold);
        int          waited;
        exp_t        e;
        logic [23:0] c_sum;
        logic [7:0]  c_cnt;
        logic        c_ovf;
        waited = 0;
        while (sum_valid !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        vectors++;
        if (sum_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL sum_valid_timeout: sum_valid=%b required 1", sum_valid);
            return;
        end
        c_sum = sum;
        c_cnt = sum_count;
        c_ovf = sum_ovf;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            vectors++;
            if (prod_ready !== 1'b0 || sum_valid !== 1'b1 || sum !== c_sum ||
                sum_count !== c_cnt || sum_ovf !== c_ovf) begin
                miscompares++;
                $display("FAIL hold_stable: ready=%b valid=%b sum=%h cnt=%0d ovf=%b required ready=0 valid=1 sum=%h cnt=%0d ovf=%b",
                         prod_ready, sum_valid, sum, sum_count, sum_ovf, c_sum, c_cnt, c_ovf);
            end
        end
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty: got sum=%h with no expected entry", sum);
        end else begin
            e = sb.pop_front();
            if (sum !== e.sum) begin
                miscompares++;
                $display("FAIL sum: got %h required %h", sum, e.sum);
            end
            vectors++;
            if (sum_count !== e.cnt) begin
                miscompares++;
                $display("FAIL sum_count: got %0d required %0d", sum_count, e.cnt);
            end
            vectors++;
            if (sum_ovf !== e.ovf) begin
                miscompares++;
                $display("FAIL sum_ovf: got %b required %b", sum_ovf, e.ovf);
            end
        end
        sum_ready = 1'b1;
        @(negedge clk);
        sum_ready = 1'b0;
        vectors++;
        if (sum_valid !== 1'b0 || prod_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL post_handshake: valid=%b ready=%b required valid=0 ready=1", sum_valid, prod_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (sum_valid !== 1'b0 || sum !== 24'd0 || sum_count !== 8'd0 || sum_ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: valid=%b sum=%h cnt=%0d ovf=%b required all 0",
                     sum_valid, sum, sum_count, sum_ovf);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (prod_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: prod_ready=%b required 1", prod_ready);
        end
    endtask

    task automatic test_signed_frame();
        send_beat(16'hFFFA, 1'b1, 1'b0);
        send_beat(16'h000A, 1'b1, 1'b0);
        send_beat(16'hFFEC, 1'b1, 1'b1);
        vectors++;
        if (sum_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL latency: sum_valid=%b required 1 one cycle after last", sum_valid);
        end
        get_sum(0);
    endtask

    task automatic test_unsigned_frame();
        send_beat(16'hFFFA, 1'b0, 1'b0);
        send_beat(16'h0001, 1'b0, 1'b1);
        get_sum(0);
    endtask

    task automatic test_backpressure();
        send_beat(16'h1234, 1'b0, 1'b0);
        send_beat(16'h8000, 1'b1, 1'b1);
        get_sum(5);
        send_beat(16'h0003, 1'b0, 1'b1);
        get_sum(0);
    endtask

    task automatic test_overflow();
        @(negedge clk);
        p4_valid  = 1'b1;
        p4_signed = 1'b1;
        p4_prod   = 8'h40;
        p4_last   = 1'b0;
        @(negedge clk);
        p4_last   = 1'b1;
        @(negedge clk);
        p4_valid  = 1'b0;
        p4_last   = 1'b0;
        vectors++;
`ifdef MUL_ACC_SAT_EN
        if (s4_valid !== 1'b1 || s4_sum !== 8'h7F || s4_ovf !== 1'b1 || s4_count !== 8'd2) begin
            miscompares++;
            $display("FAIL pos_overflow: valid=%b sum=%h ovf=%b cnt=%0d required 1 7f 1 2",
                     s4_valid, s4_sum, s4_ovf, s4_count);
        end
`else
        if (s4_valid !== 1'b1 || s4_sum !== 8'h80 || s4_ovf !== 1'b1 || s4_count !== 8'd2) begin
            miscompares++;
            $display("FAIL pos_overflow: valid=%b sum=%h ovf=%b cnt=%0d required 1 80 1 2",
                     s4_valid, s4_sum, s4_ovf, s4_count);
        end
`endif
        @(negedge clk);
        p4_valid = 1'b1;
        p4_prod  = 8'h80;
        @(negedge clk);
        p4_prod  = 8'hFF;
        p4_last  = 1'b1;
        @(negedge clk);
        p4_valid = 1'b0;
        p4_last  = 1'b0;
        vectors++;
`ifdef MUL_ACC_SAT_EN
        if (s4_sum !== 8'h80 || s4_ovf !== 1'b1) begin
            miscompares++;
            $display("FAIL neg_overflow: sum=%h ovf=%b required 80 1", s4_sum, s4_ovf);
        end
`else
        if (s4_sum !== 8'h7F || s4_ovf !== 1'b1) begin
            miscompares++;
            $display("FAIL neg_overflow: sum=%h ovf=%b required 7f 1", s4_sum, s4_ovf);
        end
`endif
        @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        send_beat(16'h0100, 1'b0, 1'b0);
        send_beat(16'h0200, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (sum_valid !== 1'b0 || sum !== 24'd0 || sum_count !== 8'd0 || sum_ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL midframe_reset: valid=%b sum=%h cnt=%0d ovf=%b required all 0",
                     sum_valid, sum, sum_count, sum_ovf);
        end
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_beat(16'h0005, 1'b0, 1'b1);
        get_sum(0);
    endtask

    task automatic test_mixed_gaps();
        send_beat(16'hFFFF, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        send_beat(16'hFFFF, 1'b0, 1'b1);
        get_sum(0);
        repeat (2) @(negedge clk);
        send_beat(16'h8001, 1'b1, 1'b1);
        get_sum(0);
    endtask

    task automatic test_count_saturation();
        for (int i = 0; i < 299; i++) begin
            send_beat(16'h0001, 1'b0, 1'b0);
        end
        send_beat(16'h0001, 1'b0, 1'b1);
        get_sum(0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        prod_valid  = 1'b0;
        prod        = '0;
        prod_signed = 1'b0;
        prod_last   = 1'b0;
        sum_ready   = 1'b0;
        p4_valid    = 1'b0;
        p4_prod     = '0;
        p4_signed   = 1'b0;
        p4_last     = 1'b0;
        rst_n       = 1'b0;
        model_clear();
        test_reset();
        test_signed_frame();
        test_unsigned_frame();
        test_backpressure();
        test_overflow();
        test_reset_mid_frame();
        test_mixed_gaps();
        test_count_saturation();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_leftover: %0d entries remain, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
